// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
// Data-memory controller for the MEM stage of the pipelined CPU.
// Handles byte/half/word loads and stores with sign/zero extension,
// a registered on-chip RAM read port, and a wait-state handshake to the
// peripheral bus with a timeout. Misaligned/illegal, unmapped and timeout
// accesses are reported as a one-cycle fault pulse with sticky address/cause.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   rd, wr              one-cycle load/store request strobes
//   addr, wdata         byte address, right-aligned store data
//   size, unsigned_ld   access size (00 byte, 01 half, 10 word), zero-extend select
//   rdata, rvalid       extended load result and its one-cycle valid pulse
//   stall               holds the MEM stage while a peripheral access is pending
//   fault, fault_addr,
//   fault_cause         fault pulse, sticky faulting address and cause
//   peri_*              peripheral bus: select, read/write, word address,
//                       lane-replicated data, byte enables, read data, ready
module data_mem_ctrl #(
  parameter int                  DEPTH_WORDS = 256,
  parameter int                  PERI_AW     = 10,
  parameter logic [31-PERI_AW:0] PERI_TAG    = 22'h100000,
  parameter int                  TIMEOUT     = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd,
  input  logic               wr,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  input  logic [1:0]         size,
  input  logic               unsigned_ld,
  output logic [31:0]        rdata,
  output logic               rvalid,
  output logic               stall,
  output logic               fault,
  output logic [31:0]        fault_addr,
  output logic [1:0]         fault_cause,
  output logic               peri_sel,
  output logic               peri_rd,
  output logic               peri_wr,
  output logic [PERI_AW-1:0] peri_addr,
  output logic [31:0]        peri_wdata,
  output logic [3:0]         peri_be,
  input  logic [31:0]        peri_rdata,
  input  logic               peri_ready
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  typedef enum logic {IDLE, PWAIT} state_t;

  state_t state, state_next;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] ram_q;
  logic        ram_pending;
  logic [31:0] rdata_r;

  logic        req_rd;
  logic [31:0] req_addr;
  logic [1:0]  ld_off;
  logic [1:0]  ld_size;
  logic        ld_uns;
  logic [7:0]  cnt;

  logic             illegal, misaligned, in_ram, in_peri, bad, req_ok;
  logic             peri_go, ram_we, ram_re, timeout_hit;
  logic [1:0]       bad_cause;
  logic [3:0]       be;
  logic [31:0]      wdata_rep;
  logic [IDX_W-1:0] idx;

  // Select the addressed lane of a raw word and sign/zero extend it.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] sz, input logic uns);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (sz)
      2'b00:   extract = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   extract = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extract = w;
    endcase
  endfunction

  // Request classification; faults are checked in priority order illegal,
  // misaligned, then region so the cause reflects the first failing check.
  assign illegal    = (rd & wr) | (size == 2'b11);
  assign misaligned = ((size == 2'b01) & addr[0]) | ((size == 2'b10) & (addr[1:0] != 2'b00));
  assign in_ram     = addr < RAM_BYTES;
  assign in_peri    = addr[31:PERI_AW] == PERI_TAG;
  assign bad        = illegal | misaligned | (~in_ram & ~in_peri);
  assign bad_cause  = (illegal | misaligned) ? 2'b01 : 2'b10;
  assign req_ok     = (state == IDLE) & (rd | wr) & ~bad;
  assign peri_go    = req_ok & ~in_ram;
  assign ram_we     = req_ok & in_ram & wr & ~reset;
  assign ram_re     = req_ok & in_ram & rd;
  assign idx        = addr[IDX_W+1:2];
  assign timeout_hit = cnt == 8'(TIMEOUT - 1);

  // Byte enables and lane-replicated store data for the addressed lanes.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    case (size)
      2'b00: begin
        be        = 4'b0001 << addr[1:0];
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << addr[1:0];
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // A RAM load is exposed directly from the registered read word during its
  // rvalid cycle; afterwards the extracted value is held in rdata_r.
  assign rdata    = ram_pending ? extract(ram_q, ld_off, ld_size, ld_uns) : rdata_r;
  assign peri_sel = state == PWAIT;
  assign peri_rd  = peri_sel & req_rd;
  assign peri_wr  = peri_sel & ~req_rd;

  // RAM array: byte-lane writes and a registered read port, never reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
    if (ram_re) ram_q <= mem[idx];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and stall. A ready arriving on the timeout edge still
  // completes the access normally.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (peri_go) begin
          state_next = PWAIT;
          stall      = 1'b1;
        end
      end
      PWAIT: begin
        stall = 1'b1;
        if (peri_ready || timeout_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: request latching, result/fault pulses and the wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid      <= 1'b0;
      fault       <= 1'b0;
      fault_addr  <= '0;
      fault_cause <= 2'b00;
      rdata_r     <= '0;
      ram_pending <= 1'b0;
      req_rd      <= 1'b0;
      req_addr    <= '0;
      ld_off      <= 2'b00;
      ld_size     <= 2'b00;
      ld_uns      <= 1'b0;
      cnt         <= '0;
      peri_addr   <= '0;
      peri_be     <= '0;
      peri_wdata  <= '0;
    end else begin
      rvalid      <= 1'b0;
      fault       <= 1'b0;
      ram_pending <= 1'b0;
      if (ram_pending) rdata_r <= extract(ram_q, ld_off, ld_size, ld_uns);
      case (state)
        IDLE: begin
          cnt <= '0;
          if ((rd | wr) && bad) begin
            fault       <= 1'b1;
            fault_addr  <= addr;
            fault_cause <= bad_cause;
          end else if (ram_re) begin
            rvalid      <= 1'b1;
            ram_pending <= 1'b1;
            ld_off      <= addr[1:0];
            ld_size     <= size;
            ld_uns      <= unsigned_ld;
          end else if (peri_go) begin
            req_rd     <= rd;
            req_addr   <= addr;
            ld_off     <= addr[1:0];
            ld_size    <= size;
            ld_uns     <= unsigned_ld;
            peri_addr  <= {addr[PERI_AW-1:2], 2'b00};
            peri_be    <= be;
            peri_wdata <= wdata_rep;
          end
        end
        PWAIT: begin
          cnt <= cnt + 8'd1;
          if (peri_ready) begin
            cnt <= '0;
            if (req_rd) begin
              rvalid  <= 1'b1;
              rdata_r <= extract(peri_rdata, ld_off, ld_size, ld_uns);
            end
          end else if (timeout_hit) begin
            cnt         <= '0;
            fault       <= 1'b1;
            fault_addr  <= req_addr;
            fault_cause <= 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised data-memory controller for the pipelined CPU's MEM stage. Replaces the word-only, combinational-read memory.
- Adds byte/half/word accesses with sign/zero extension, a registered RAM read port, and a wait-state handshake to the peripheral/UART bus with timeout.
- Flags access faults: misaligned, unmapped and timeout. The CPU's exception logic consumes them.

Parameters:
DEPTH_WORDS, 256, RAM size in 32-bit words (power of 2); RAM occupies byte addresses 0 .. 4*DEPTH_WORDS-1
PERI_TAG, 22'h100000, value addr[31:PERI_AW] must equal to select the peripheral region
PERI_AW, 10, peripheral byte-address width passed through
TIMEOUT, 15, max cycles spent waiting for peri_ready before a timeout fault (1..255)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rd  in  1  load request (one-cycle strobe)
wr  in  1  store request (one-cycle strobe)
addr  in  32  byte address
wdata  in  32  store data, right-aligned
size  in  2  00 byte, 01 half, 10 word, 11 illegal
unsigned_ld  in  1  1 = zero-extend loads, 0 = sign-extend
rdata  out  32  extended load result, valid when rvalid
rvalid  out  1  one-cycle pulse: load data ready
stall  out  1  hold the MEM stage
fault  out  1  one-cycle pulse: access faulted
fault_addr  out  32  address of the last faulting access (sticky)
fault_cause  out  2  01 misaligned/illegal, 10 unmapped, 11 timeout (sticky)
peri_sel  out  1  peripheral transaction active
peri_rd  out  1  peripheral read
peri_wr  out  1  peripheral write
peri_addr  out  PERI_AW  word-aligned peripheral address
peri_wdata  out  32  lane-replicated store data
peri_be  out  4  byte enables
peri_rdata  in  32  peripheral read data, raw word
peri_ready  in  1  peripheral completes the transaction this cycle

Behaviour:
- Reset values (state after any cycle with reset=1): rdata=0, rvalid=0, stall=0, fault=0, fault_addr=0, fault_cause=00, all peri_* outputs 0, FSM=IDLE, timeout counter=0. RAM contents are not cleared. Reset aborts a PWAIT transaction with no fault raised.
- Requests are accepted only in IDLE.
- Request checks, in priority order:
  - rd&wr both high, or size=11 → misaligned/illegal fault.
  - Misaligned → misaligned fault: half access with addr[0]=1, or word access with addr[1:0]!=0.
  - Region decode:
    - RAM when addr < 4*DEPTH_WORDS.
    - Peripheral when addr[31:PERI_AW]==PERI_TAG.
    - Otherwise unmapped fault.
- Any fault:
  - No RAM write, no peripheral strobe.
  - Next edge: fault=1 for 1 cycle; fault_addr and fault_cause updated.
  - rvalid stays 0.
- Byte enables: byte → 1<<addr[1:0]; half → 4'b0011<<addr[1:0]; word → 4'b1111.
- Store data is replicated across lanes: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}.
- RAM store: written at the request edge, enabled lanes only. stall=0. Zero wait.
- RAM load:
  - Word read at the request edge.
  - Next cycle: rvalid=1; rdata holds the extracted lane, sign/zero extended per unsigned_ld.
  - Latency 1. stall=0.
  - Store then load to the same address on the next cycle returns the new data.
- Peripheral access FSM, states IDLE and PWAIT:
  - Request cycle: stall=1 combinationally; at the edge, latch addr/size/be/data/type and enter PWAIT.
  - In PWAIT: peri_sel=1; peri_rd or peri_wr=1; peri_addr/peri_be/peri_wdata held; stall=1; counter increments each cycle.
  - Edge where peri_ready=1 → IDLE. For a load, rdata is extracted from peri_rdata and rvalid=1 next cycle. stall is 0 from the IDLE cycle onward.
  - Counter reaching TIMEOUT with peri_ready=0 → IDLE, timeout fault, rvalid=0.
  - peri_ready arriving on the same edge as the timeout wins; no fault.
  - Minimum peripheral latency is 2 cycles: request + 1 PWAIT with immediate ready.
- rd/wr asserted while stall=1 are ignored. The CPU holds the instruction and does not re-strobe.
- rvalid and fault never assert in the same cycle.

Test Plan:
- Store word 0xDEADBEEF @0x10, next cycle load word @0x10 → rvalid next cycle, rdata=0xDEADBEEF, stall stays 0.
- Store byte 0x80 @0x13, then load byte signed @0x13 → 0xFFFFFF80. Unsigned → 0x00000080. Half unsigned @0x12 → 0x000080AD.
- Load half @0x11 → fault pulse, cause=01, fault_addr=0x11, no rvalid. rd&wr together → cause=01.
- Load @0x0000_2000 with DEPTH_WORDS=256 (outside RAM and peripheral region) → cause=10. RAM @0x3FC unaffected.
- Peripheral load @0x4000_0014:
  - peri_ready after 3 PWAIT cycles, peri_rdata=0x12345678.
  - stall=1 for 4 cycles, peri_addr=0x014, peri_be=4'hF.
  - rdata=0x12345678 with rvalid.
- Peripheral store with peri_ready tied 0, TIMEOUT=15 → 15 PWAIT cycles, then fault cause=11. Reset asserted mid-PWAIT → IDLE, all outputs 0, no fault.
